instr_fetch: RTL and testbench

//  Upstream neighbour of the single-cycle datapath. Holds the program counter
//  and the architectural flag register (N,Z,V,C). Slices the 32-bit instruction

---
 rtl/instr_fetch.sv | 146 ++++++++++++++
 tb/tb_instr_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter, flag register, field slicing and branch resolve
//
// instr_fetch: holds the PC and the {N,Z,V,C} flag register, slices the
// instruction word into datapath fields and computes the next PC.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   instruction[31:0]    instruction word fetched at pc
//   stall                hold pc and flags this cycle
//   setFlags             latch ALU flags (ADDS/SUBS)
//   alu_negative/zero/overflow/carry  ALU status of the current instruction
//   pc[63:0]             current PC (instruction memory address)
//   opcode, Rd, Rn, Rm, Daddr9, Imm12  instruction fields
//   brTaken              next pc is a branch target
//   flags[3:0]           registered {N,Z,V,C}
//
// mux2_1:  one-bit 2:1 mux, out = sel ? i1 : i0
// adder64: 64-bit ripple-carry adder, carry-out discarded (wraps mod 2^64)

module mux2_1 (
  input  logic i0,
  input  logic i1,
  input  logic sel,
  output logic out
);
  assign out = (i1 & sel) | (i0 & ~sel);
endmodule

module adder64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);
  logic [63:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 64; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    // The carry out of bit 63 is dropped, so the sum wraps modulo 2^64.
    if (i < 63) begin : g_carry
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end
endmodule

module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        setFlags,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  output logic [63:0] pc,
  output logic [10:0] opcode,
  output logic [4:0]  Rd,
  output logic [4:0]  Rn,
  output logic [4:0]  Rm,
  output logic [8:0]  Daddr9,
  output logic [11:0] Imm12,
  output logic        brTaken,
  output logic [3:0]  flags
);
  logic        is_b;
  logic        is_cbz;
  logic        is_bcond;
  logic        cond_ok;
  logic [63:0] off_b;
  logic [63:0] off_cb;
  logic [63:0] off_sel;
  logic [63:0] target;
  logic [63:0] seq_pc;
  logic [63:0] next_pc;

  assign opcode = instruction[31:21];
  assign Rd     = instruction[4:0];
  assign Rn     = instruction[9:5];
  assign Rm     = instruction[20:16];
  assign Daddr9 = instruction[20:12];
  assign Imm12  = instruction[21:10];

  assign is_b     = (instruction[31:26] == 6'b000101);
  assign is_cbz   = (instruction[31:24] == 8'b10110100);
  assign is_bcond = (instruction[31:24] == 8'b01010100);

  // B.cond looks only at the registered flags; a same-cycle setFlags
  // does not forward into the decision.
  always_comb begin
    cond_ok = 1'b0;
    case (instruction[4:0])
      5'h00:   cond_ok = flags[2];              // EQ
      5'h01:   cond_ok = ~flags[2];             // NE
      5'h0B:   cond_ok = flags[3] ^ flags[1];   // LT: N != V
      default: cond_ok = 1'b0;
    endcase
  end

  assign brTaken = is_b | (is_cbz & alu_zero) | (is_bcond & cond_ok);

  // Word offsets, sign-extended and already shifted left by two.
  assign off_b  = {{36{instruction[25]}}, instruction[25:0], 2'b00};
  assign off_cb = {{43{instruction[23]}}, instruction[23:5], 2'b00};

  for (genvar i = 0; i < 64; i++) begin : g_mux
    mux2_1 u_off_mux (
      .i0  (off_cb[i]),
      .i1  (off_b[i]),
      .sel (is_b),
      .out (off_sel[i])
    );
    mux2_1 u_next_mux (
      .i0  (seq_pc[i]),
      .i1  (target[i]),
      .sel (brTaken),
      .out (next_pc[i])
    );
  end

  adder64 u_target_add (
    .a   (pc),
    .b   (off_sel),
    .sum (target)
  );

  adder64 u_seq_add (
    .a   (pc),
    .b   (64'd4),
    .sum (seq_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      flags <= 4'b0000;
    end else if (!stall) begin
      pc <= next_pc;
      if (setFlags) begin
        flags <= {alu_negative, alu_zero, alu_overflow, alu_carry};
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed vector bench for instr_fetch

module tb_instr_fetch;
  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        stall;
  logic        setFlags;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_carry;
  logic [63:0] pc;
  logic [10:0] opcode;
  logic [4:0]  Rd;
  logic [4:0]  Rn;
  logic [4:0]  Rm;
  logic [8:0]  Daddr9;
  logic [11:0] Imm12;
  logic        brTaken;
  logic [3:0]  flags;

  instr_fetch #(.RESET_PC(64'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .stall        (stall),
    .setFlags     (setFlags),
    .alu_negative (alu_negative),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .pc           (pc),
    .opcode       (opcode),
    .Rd           (Rd),
    .Rn           (Rn),
    .Rm           (Rm),
    .Daddr9       (Daddr9),
    .Imm12        (Imm12),
    .brTaken      (brTaken),
    .flags        (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP   = 32'h8B020020;  // ADD
  localparam logic [31:0] SUBS  = 32'hEB020020;
  localparam logic [31:0] B_M1  = 32'h17FFFFFF;  // B -1
  localparam logic [31:0] B_M2  = 32'h17FFFFFE;  // B -2
  localparam logic [31:0] B_M3  = 32'h17FFFFFD;  // B -3
  localparam logic [31:0] CBZ3  = 32'hB4000060;  // CBZ imm19=3
  localparam logic [31:0] B_LT  = 32'h5400004B;  // B.LT imm19=2
  localparam logic [31:0] B_EQ  = 32'h54000040;
  localparam logic [31:0] B_NE  = 32'h54000041;
  localparam logic [31:0] B_CS  = 32'h54000042;  // unsupported cond

  typedef struct {
    logic        rst;
    logic        stl;
    logic        setf;
    logic [31:0] instr;
    logic [3:0]  alu;      // {N,Z,V,C}
    logic        exp_br;   // before the edge
    logic [63:0] exp_pc;   // after the edge
    logic [3:0]  exp_flags;
  } vec_t;

  vec_t vecs[$];
  int   n_applied = 0;
  int   n_miss = 0;

  function automatic void add(input logic rst, input logic stl, input logic setf,
                              input logic [31:0] instr, input logic [3:0] alu,
                              input logic br, input logic [63:0] epc,
                              input logic [3:0] ef);
    vec_t v;
    v.rst = rst; v.stl = stl; v.setf = setf; v.instr = instr; v.alu = alu;
    v.exp_br = br; v.exp_pc = epc; v.exp_flags = ef;
    vecs.push_back(v);
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; setFlags = 1'b0; instruction = NOP;
    {alu_negative, alu_zero, alu_overflow, alu_carry} = 4'b0000;

    // reset, sequential fetch
    add(1, 0, 0, NOP,   4'b0000, 0, 64'd0,  4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd4,  4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd8,  4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd12, 4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd16, 4'b0000);
    // B backwards
    add(0, 0, 0, B_M2,  4'b0000, 1, 64'd8,  4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd12, 4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd16, 4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd20, 4'b0000);
    // CBZ taken / not taken
    add(0, 0, 0, CBZ3,  4'b0100, 1, 64'd32, 4'b0000);
    add(0, 0, 0, B_M3,  4'b0000, 1, 64'd20, 4'b0000);
    add(0, 0, 0, CBZ3,  4'b0000, 0, 64'd24, 4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd28, 4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd32, 4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd36, 4'b0000);
    // SUBS N=1 V=0 then B.LT taken
    add(0, 0, 1, SUBS,  4'b1000, 0, 64'd40, 4'b1000);
    add(0, 0, 0, B_LT,  4'b0000, 1, 64'd48, 4'b1000);
    add(0, 0, 0, B_M3,  4'b0000, 1, 64'd36, 4'b1000);
    // SUBS N=1 V=1 then B.LT not taken
    add(0, 0, 1, SUBS,  4'b1010, 0, 64'd40, 4'b1010);
    add(0, 0, 0, B_LT,  4'b0000, 0, 64'd44, 4'b1010);
    add(0, 0, 0, B_EQ,  4'b0000, 0, 64'd48, 4'b1010);
    add(0, 0, 0, B_NE,  4'b0000, 1, 64'd56, 4'b1010);
    // B.EQ ignores same-cycle ALU zero
    add(0, 0, 0, B_EQ,  4'b0100, 0, 64'd60, 4'b1010);
    add(0, 0, 0, B_CS,  4'b0000, 0, 64'd64, 4'b1010);
    // B.LT with setFlags: decides on old flags, new flags still latch
    add(0, 0, 1, B_LT,  4'b1000, 0, 64'd68, 4'b1000);
    // stall holds pc and flags, even with setFlags and a taken branch
    add(0, 1, 1, NOP,   4'b0101, 0, 64'd68, 4'b1000);
    add(0, 1, 1, NOP,   4'b0101, 0, 64'd68, 4'b1000);
    add(0, 1, 1, NOP,   4'b0101, 0, 64'd68, 4'b1000);
    add(0, 1, 0, B_M2,  4'b0000, 1, 64'd68, 4'b1000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd72, 4'b1000);
    // wrap below zero and above 2^64-4
    add(1, 0, 0, NOP,   4'b0000, 0, 64'd0,  4'b0000);
    add(0, 0, 0, B_M1,  4'b0000, 1, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0000);
    add(0, 0, 0, NOP,   4'b0000, 0, 64'd0,  4'b0000);
    add(0, 0, 1, SUBS,  4'b0111, 0, 64'd4,  4'b0111);
    // reset beats stall and setFlags
    add(1, 1, 1, NOP,   4'b1111, 0, 64'd0,  4'b0000);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      stall = vecs[i].stl;
      setFlags = vecs[i].setf;
      instruction = vecs[i].instr;
      {alu_negative, alu_zero, alu_overflow, alu_carry} = vecs[i].alu;
      #1;
      check64($sformatf("v%0d brTaken", i), {63'd0, brTaken}, {63'd0, vecs[i].exp_br});
      @(posedge clk);
      #1;
      check64($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
      check64($sformatf("v%0d flags", i), {60'd0, flags}, {60'd0, vecs[i].exp_flags});
    end

    // field slicing, held under stall
    @(negedge clk);
    reset = 1'b0; stall = 1'b1; setFlags = 1'b0;
    instruction = 32'hDEADBEEF;
    #1;
    check64("opcode", {53'd0, opcode}, 64'h6F5);
    check64("Rd",     {59'd0, Rd},     64'h0F);
    check64("Rn",     {59'd0, Rn},     64'h17);
    check64("Rm",     {59'd0, Rm},     64'h0D);
    check64("Daddr9", {55'd0, Daddr9}, 64'h0DB);
    check64("Imm12",  {52'd0, Imm12},  64'hB6F);
    check64("brTaken field", {63'd0, brTaken}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end
endmodule
